// File: rtl/div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_unit_pkg
// Description : Shared constants for the multicycle signed divider.
// Revision    : 1.0 - initial release
// ============================================================================
package div_unit_pkg;

    localparam logic [1:0]  DIV_IDLE  = 2'd0;
    localparam logic [1:0]  DIV_RUN   = 2'd1;
    localparam logic [1:0]  DIV_SIGN  = 2'd2;
    localparam logic [1:0]  DIV_DONE  = 2'd3;

    localparam int          DIV_ITERS = 32;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;

    // The only signed quotient that cannot be represented in 32 bits.
    function automatic logic div_is_overflow(input logic [31:0] a, input logic [31:0] b);
        return (a == INT_MIN) && (b == 32'hFFFF_FFFF);
    endfunction

endpackage
`default_nettype wire

// File: rtl/SUB.sv
`default_nettype none
// ============================================================================
// Module      : SUB
// Description : 32-bit subtractor, o_diff = i_a - i_b; o_c32 is the carry out
//               of the adder, i.e. 1 when no borrow occurred (i_a >= i_b).
// Revision    : 1.0 - initial release
// ============================================================================
module SUB (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_diff,
    output logic        o_c32
);

    assign {o_c32, o_diff} = {1'b0, i_a} + {1'b0, ~i_b} + 33'd1;

endmodule
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module      : div_unit
// Description : Multicycle 32-bit signed restoring divider, one quotient bit
//               per cycle, sign-corrected result with a one-cycle ready pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module div_unit #(
    parameter int DIV_ITERS = div_unit_pkg::DIV_ITERS
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);

    import div_unit_pkg::*;

    localparam int                 c_CNT_W   = $clog2(DIV_ITERS) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST    = c_CNT_W'(DIV_ITERS - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    logic [1:0]         r_state;
    logic [31:0]        r_rem;
    logic [31:0]        r_quo;
    logic [31:0]        r_div;
    logic [c_CNT_W-1:0] r_count;
    logic               r_neg;
    logic               r_ovf;
    logic               r_dz_pend;

    logic               w_start;
    logic [63:0]        w_shift;
    logic [31:0]        w_rem_sh;
    logic [31:0]        w_quo_sh;
    logic [31:0]        w_trial_a;
    logic [31:0]        w_trial_b;
    logic [31:0]        w_trial_diff;
    logic               w_trial_c32;
    logic [31:0]        w_neg_a;
    logic               w_a_zero;
    logic [31:0]        w_neg_q;
    logic               w_q_zero;

    assign w_start = ctrl_DIV && !r_dz_pend &&
                     ((r_state == DIV_IDLE) || (r_state == DIV_DONE));

    assign w_shift  = {r_rem, r_quo} << 1;
    assign w_rem_sh = w_shift[63:32];
    assign w_quo_sh = w_shift[31:0];

    // The trial subtractor is idle on the start edge, so it doubles as the
    // divisor negator there; its no-borrow flag then means "divisor is zero".
    assign w_trial_a = w_start ? 32'd0         : w_rem_sh;
    assign w_trial_b = w_start ? data_operandB : r_div;

    SUB u_sub_trial (
        .i_a    (w_trial_a),
        .i_b    (w_trial_b),
        .o_diff (w_trial_diff),
        .o_c32  (w_trial_c32)
    );

    SUB u_sub_abs (
        .i_a    (32'd0),
        .i_b    (data_operandA),
        .o_diff (w_neg_a),
        .o_c32  (w_a_zero)
    );

    SUB u_sub_sign (
        .i_a    (32'd0),
        .i_b    (r_quo),
        .o_diff (w_neg_q),
        .o_c32  (w_q_zero)
    );

    assign busy = (r_state == DIV_RUN) || (r_state == DIV_SIGN);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= DIV_IDLE;
            r_rem          <= '0;
            r_quo          <= '0;
            r_div          <= '0;
            r_count        <= '0;
            r_neg          <= 1'b0;
            r_ovf          <= 1'b0;
            r_dz_pend      <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            r_dz_pend      <= 1'b0;
            if (r_dz_pend) begin
                r_state        <= DIV_DONE;
                data_result    <= '0;
                data_exception <= 1'b1;
                data_resultRDY <= 1'b1;
            end else if (w_start) begin
                r_div          <= data_operandB[31] ? w_trial_diff : data_operandB;
                r_quo          <= data_operandA[31] ? w_neg_a : data_operandA;
                r_rem          <= '0;
                r_count        <= '0;
                // A zero dividend gives a zero quotient whatever the signs.
                r_neg          <= (data_operandA[31] ^ data_operandB[31]) & ~w_a_zero;
                r_ovf          <= div_is_overflow(data_operandA, data_operandB);
                data_exception <= 1'b0;
                if (w_trial_c32) begin
                    r_dz_pend <= 1'b1;
                    r_state   <= DIV_IDLE;
                end else begin
                    r_state   <= DIV_RUN;
                end
            end else begin
                case (r_state)
                    DIV_RUN: begin
                        if (w_trial_c32) begin
                            r_rem <= w_trial_diff;
                        end else begin
                            r_rem <= w_rem_sh;
                        end
                        r_quo   <= w_quo_sh | {31'd0, w_trial_c32};
                        r_count <= r_count + c_CNT_ONE;
                        if (r_count == c_LAST) begin
                            r_state <= DIV_SIGN;
                        end
                    end
                    DIV_SIGN: begin
                        if (r_ovf) begin
                            data_result <= INT_MIN;
                        end else if (r_neg && !w_q_zero) begin
                            data_result <= w_neg_q;
                        end else begin
                            data_result <= r_quo;
                        end
                        data_exception <= r_ovf;
                        data_resultRDY <= 1'b1;
                        r_state        <= DIV_DONE;
                    end
                    DIV_DONE: begin
                        r_state <= DIV_IDLE;
                    end
                    default: begin
                        r_state <= DIV_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_unit
// Description : Directed, table-driven self-checking bench for div_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit;

    logic        clk;
    logic        rst_n;
    logic        ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] result;
    logic        exc;
    logic        rdy;
    logic        busy;

    int n_err    = 0;
    int n_checks = 0;

    div_unit dut (
        .clock          (clk),
        .reset_n        (rst_n),
        .ctrl_DIV       (ctrl),
        .data_operandA  (op_a),
        .data_operandB  (op_b),
        .data_result    (result),
        .data_exception (exc),
        .data_resultRDY (rdy),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic        e;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Start one division, optionally poke ctrl_DIV after poke_at edges, then
    // wait (bounded) for the ready pulse and check result and timing.
    task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic ee, input int elat,
                          input int poke_at);
        int  n;
        logic first_busy;
        logic saw_busy;
        @(negedge clk);
        ctrl = 1'b1; op_a = a; op_b = b;
        @(negedge clk);
        ctrl = 1'b0; op_a = $urandom; op_b = $urandom;
        n = 0;
        first_busy = busy;
        saw_busy = busy;
        while (!rdy && n < 60) begin
            @(negedge clk);
            n++;
            if (n == poke_at) begin
                ctrl = 1'b1; op_a = 32'd1; op_b = 32'd1;
            end else begin
                ctrl = 1'b0;
            end
            if (!rdy && busy) saw_busy = 1'b1;
        end
        ctrl = 1'b0;
        check({tag, " latency"}, n, elat);
        check({tag, " result"}, result, eq);
        check({tag, " exception"}, {31'd0, exc}, {31'd0, ee});
        check({tag, " busy"}, {30'd0, first_busy, saw_busy}, (elat == 1) ? 32'd0 : 32'd3);
        check({tag, " busy low in done"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
        check({tag, " ready one cycle"}, {31'd0, rdy}, 32'd0);
    endtask

    initial begin
        int m;
        logic saw_rdy;

        vecs[0]  = '{32'd100,      32'd7,        32'd14,       1'b0, 33};
        vecs[1]  = '{32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 1'b0, 33};
        vecs[2]  = '{32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0, 33};
        vecs[3]  = '{32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       1'b0, 33};
        vecs[4]  = '{32'd5,        32'd0,        32'd0,        1'b1, 1};
        vecs[5]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 33};
        vecs[6]  = '{32'h80000000, 32'd1,        32'h80000000, 1'b0, 33};
        vecs[7]  = '{32'd0,        32'd5,        32'd0,        1'b0, 33};
        vecs[8]  = '{32'd7,        32'd100,      32'd0,        1'b0, 33};
        vecs[9]  = '{32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 33};
        vecs[10] = '{32'h80000000, 32'h80000000, 32'd1,        1'b0, 33};
        vecs[11] = '{32'h7FFFFFFF, 32'd2,        32'h3FFFFFFF, 1'b0, 33};
        vecs[12] = '{32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 33};
        vecs[13] = '{32'd1000000,  32'hFFFFFFFD, 32'hFFFAE9EB, 1'b0, 33};

        rst_n = 1'b0; ctrl = 1'b0; op_a = '0; op_b = '0;
        repeat (3) @(negedge clk);
        check("reset result", result, 32'd0);
        check("reset flags", {29'd0, exc, rdy, busy}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            do_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q,
                   vecs[i].e, vecs[i].lat, -1);
        end

        // Divide-by-zero right after a normal result must still report zero.
        do_div("dz after 0/0", 32'd0, 32'd0, 32'd0, 1'b1, 1, -1);

        // A start request in the middle of RUN is ignored.
        do_div("start ignored", 32'd100, 32'd7, 32'd14, 1'b0, 33, 10);

        // Reset mid-operation aborts at once and never produces a ready.
        @(negedge clk);
        ctrl = 1'b1; op_a = 32'd200; op_b = 32'd3;
        @(negedge clk);
        ctrl = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort result", result, 32'd0);
        check("abort flags", {29'd0, exc, rdy, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_rdy = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (rdy) saw_rdy = 1'b1;
        end
        check("abort no ready", {31'd0, saw_rdy}, 32'd0);
        do_div("after abort 9/3", 32'd9, 32'd3, 32'd3, 1'b0, 33, -1);

        // Back-to-back: new start accepted in the DONE cycle.
        @(negedge clk);
        ctrl = 1'b1; op_a = 32'd8; op_b = 32'd2;
        @(negedge clk);
        ctrl = 1'b0;
        m = 0;
        while (!rdy && m < 60) begin
            @(negedge clk);
            m++;
        end
        check("b2b first latency", m, 33);
        check("b2b first result", result, 32'd4);
        ctrl = 1'b1; op_a = 32'd50; op_b = 32'd5;
        @(negedge clk);
        ctrl = 1'b0; op_a = $urandom; op_b = $urandom;
        check("b2b ready dropped", {30'd0, rdy, busy}, 32'd1);
        m = 1;
        while (!rdy && m < 80) begin
            @(negedge clk);
            m++;
        end
        check("b2b second spacing", m, 34);
        check("b2b second result", result, 32'd10);
        check("b2b second exception", {31'd0, exc}, 32'd0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
